sum_ascii_framer: RTL and testbench

SUM_ASCII_FRAMER -- requirements
Module: sum_ascii_framer

---
 rtl/sum_ascii_framer_pkg.sv | 14 +
 rtl/sum_bcd_split.sv | 13 +
 rtl/sum_ascii_framer.sv | 93 +++++++++
 tb/tb_sum_ascii_framer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sum_ascii_framer_pkg.sv
// sum_ascii_framer_pkg: FSM states, ASCII constants and frame byte selection for the sum framer.
package sum_ascii_framer_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, STROBE, WAIT_HI, WAIT_LO, NEXT} state_t;
   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_CR = 8'h0D;
   localparam logic [7:0] ASCII_LF = 8'h0A;
   localparam int FRAME_LEN_CRLF = 4;
   localparam int FRAME_LEN_BARE = 2;
   function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [1:0] tens, input logic [3:0] ones);
      return idx == 2'd0 ? ASCII_ZERO + {6'd0, tens} :
             idx == 2'd1 ? ASCII_ZERO + {4'd0, ones} :
             idx == 2'd2 ? ASCII_CR : ASCII_LF;
   endfunction
endpackage

// File: rtl/sum_bcd_split.sv
// sum_bcd_split: splits a 0..31 value into a decimal tens digit and ones digit.
module sum_bcd_split (
   input  logic [4:0] sum,
   output logic [1:0] tens,
   output logic [3:0] ones
);
   logic [4:0] off;
   always_comb begin
      tens = sum >= 5'd30 ? 2'd3 : sum >= 5'd20 ? 2'd2 : sum >= 5'd10 ? 2'd1 : 2'd0;
      off = sum >= 5'd30 ? 5'd30 : sum >= 5'd20 ? 5'd20 : sum >= 5'd10 ? 5'd10 : 5'd0;
      ones = 4'(sum - off);
   end
endmodule

// File: rtl/sum_ascii_framer.sv
// sum_ascii_framer: sends a captured 5-bit sum as two ASCII digits (plus optional CR LF)
// through a busy/enable UART handshake; all outputs are registered.
module sum_ascii_framer
   import sum_ascii_framer_pkg::*;
#(
   parameter bit SEND_CRLF = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sum_valid,
   input  logic [4:0] sum_in,
   input  logic       uart_tx_busy,
   output logic       uart_tx_en,
   output logic [7:0] uart_tx_data,
   output logic       busy,
   output logic       frame_done,
   output logic       overrun
);
   localparam logic [1:0] LAST = SEND_CRLF ? 2'(FRAME_LEN_CRLF - 1) : 2'(FRAME_LEN_BARE - 1);
   state_t state, state_n;
   logic [4:0] sum_r, sum_n;
   logic [1:0] idx, idx_n;
   logic [1:0] tens;
   logic [3:0] ones;
   logic       en_n, busy_n, done_n, overrun_n;
   logic [7:0] data_n;

   sum_bcd_split split (
      .sum (sum_r),
      .tens(tens),
      .ones(ones)
   );

   // frame_done is raised while still in NEXT, so a sum_valid in that cycle counts as an overrun
   always_comb begin
      state_n = state;
      sum_n = sum_r;
      idx_n = idx;
      en_n = 1'b0;
      data_n = uart_tx_data;
      done_n = 1'b0;
      overrun_n = overrun | (sum_valid && state != IDLE);
      case (state)
         IDLE: if (sum_valid) begin
            sum_n = sum_in;
            state_n = LOAD;
         end
         LOAD: begin
            idx_n = 2'd0;
            data_n = frame_byte(2'd0, tens, ones);
            state_n = STROBE;
         end
         STROBE: if (!uart_tx_busy) begin
            en_n = 1'b1;
            state_n = WAIT_HI;
         end
         WAIT_HI: if (uart_tx_busy) state_n = WAIT_LO;
         WAIT_LO: if (!uart_tx_busy) begin
            done_n = idx == LAST;
            state_n = NEXT;
         end
         NEXT: if (idx != LAST) begin
            idx_n = idx + 2'd1;
            data_n = frame_byte(idx + 2'd1, tens, ones);
            state_n = STROBE;
         end else state_n = IDLE;
         default: state_n = IDLE;
      endcase
      busy_n = state_n != IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         sum_r <= '0;
         idx <= '0;
         uart_tx_en <= 1'b0;
         uart_tx_data <= '0;
         busy <= 1'b0;
         frame_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_n;
         sum_r <= sum_n;
         idx <= idx_n;
         uart_tx_en <= en_n;
         uart_tx_data <= data_n;
         busy <= busy_n;
         frame_done <= done_n;
         overrun <= overrun_n;
      end
   end
endmodule

// File: tb/tb_sum_ascii_framer.sv
// tb_sum_ascii_framer: drives two framers (with and without CR LF) against a simple UART busy model.
module tb_sum_ascii_framer;
   typedef struct {
      int          k;
      logic [4:0]  s;
      int          hold;
      int          n;
      logic [31:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       sv[2];
   logic [4:0] si[2];
   logic       ub[2];
   logic       frc[2];
   logic       ub_in[2];
   logic       en[2];
   logic [7:0] dat[2];
   logic       bsy[2];
   logic       dn[2];
   logic       ovr[2];
   int         hold[2];
   int         cnt[2];
   int         ncap[2];
   int         ndone[2];
   int         ewb[2];
   logic [7:0] cap[2][64];
   int         total = 0;
   int         bad = 0;
   vec_t       vecs[9];

   always #5 clk = ~clk;

   assign ub_in[0] = ub[0] | frc[0];
   assign ub_in[1] = ub[1] | frc[1];

   sum_ascii_framer #(.SEND_CRLF(1'b1)) dut0 (
      .clk(clk), .reset(rst), .sum_valid(sv[0]), .sum_in(si[0]), .uart_tx_busy(ub_in[0]),
      .uart_tx_en(en[0]), .uart_tx_data(dat[0]), .busy(bsy[0]), .frame_done(dn[0]), .overrun(ovr[0])
   );

   sum_ascii_framer #(.SEND_CRLF(1'b0)) dut1 (
      .clk(clk), .reset(rst), .sum_valid(sv[1]), .sum_in(si[1]), .uart_tx_busy(ub_in[1]),
      .uart_tx_en(en[1]), .uart_tx_data(dat[1]), .busy(bsy[1]), .frame_done(dn[1]), .overrun(ovr[1])
   );

   // UART model: busy rises after each accepted strobe and stays high for hold cycles
   initial begin
      for (int k = 0; k < 2; k++) begin
         ub[k] = 1'b0;
         cnt[k] = 0;
         ncap[k] = 0;
         ndone[k] = 0;
         ewb[k] = 0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (en[k] && ub_in[k]) ewb[k]++;
            if (en[k]) begin
               if (ncap[k] < 64) cap[k][ncap[k]] = dat[k];
               ncap[k]++;
            end
            if (dn[k]) ndone[k]++;
            if (en[k] && !ub[k]) begin
               ub[k] = 1'b1;
               cnt[k] = hold[k];
            end else if (ub[k]) begin
               cnt[k]--;
               if (cnt[k] <= 0) ub[k] = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic send(input int k, input logic [4:0] s);
      si[k] = s;
      sv[k] = 1'b1;
      tick();
      sv[k] = 1'b0;
   endtask

   task automatic wait_done(input int k, input string nm);
      int c = 0;
      while (!dn[k] && c < 2000) begin
         tick();
         c++;
      end
      chk({nm, " done seen"}, 32'(dn[k]), 32'd1);
   endtask

   task automatic check_frame(input int k, input int base, input int n, input logic [31:0] exp, input string nm);
      chk({nm, " strobes"}, 32'(ncap[k] - base), 32'(n));
      for (int i = 0; i < n; i++)
         if (base + i < 64) chk($sformatf("%s byte%0d", nm, i), 32'(cap[k][base + i]), 32'(exp[31 - 8 * i -: 8]));
   endtask

   task automatic check_zero(input int k, input string nm);
      chk({nm, " en"}, 32'(en[k]), 32'd0);
      chk({nm, " data"}, 32'(dat[k]), 32'd0);
      chk({nm, " busy"}, 32'(bsy[k]), 32'd0);
      chk({nm, " done"}, 32'(dn[k]), 32'd0);
      chk({nm, " overrun"}, 32'(ovr[k]), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base, d0, c;
      vecs[0] = '{0, 5'd17, 3, 4, 32'h3137_0D0A};
      vecs[1] = '{0, 5'd0, 3, 4, 32'h3030_0D0A};
      vecs[2] = '{0, 5'd31, 3, 4, 32'h3331_0D0A};
      vecs[3] = '{0, 5'd17, 100, 4, 32'h3137_0D0A};
      vecs[4] = '{1, 5'd0, 3, 2, 32'h3030_0000};
      vecs[5] = '{1, 5'd31, 5, 2, 32'h3331_0000};
      vecs[6] = '{1, 5'd10, 1, 2, 32'h3130_0000};
      vecs[7] = '{1, 5'd29, 2, 2, 32'h3239_0000};
      vecs[8] = '{0, 5'd9, 1, 4, 32'h3039_0D0A};
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         sv[k] = 1'b0;
         si[k] = '0;
         frc[k] = 1'b0;
         hold[k] = 3;
      end
      repeat (3) tick();
      check_zero(0, "reset crlf");
      check_zero(1, "reset bare");
      rst = 1'b0;
      tick();

      foreach (vecs[i]) begin
         hold[vecs[i].k] = vecs[i].hold;
         base = ncap[vecs[i].k];
         d0 = ndone[vecs[i].k];
         send(vecs[i].k, vecs[i].s);
         wait_done(vecs[i].k, $sformatf("vec%0d", i));
         repeat (10) tick();
         check_frame(vecs[i].k, base, vecs[i].n, vecs[i].exp, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d frame_done count", i), 32'(ndone[vecs[i].k] - d0), 32'd1);
      end

      hold[0] = 3;
      base = ncap[0];
      si[0] = 5'd5;
      sv[0] = 1'b1;
      tick();
      sv[0] = 1'b0;
      c = 1;
      chk("latency busy rise", 32'(bsy[0]), 32'd1);
      while (!en[0] && c < 20) begin
         tick();
         c++;
      end
      chk("latency to first strobe", 32'(c), 32'd3);
      wait_done(0, "latency");
      repeat (5) tick();
      check_frame(0, base, 4, 32'h3035_0D0A, "latency");

      hold[1] = 3;
      frc[1] = 1'b1;
      base = ncap[1];
      send(1, 5'd22);
      repeat (10) tick();
      chk("stall no strobe", 32'(ncap[1] - base), 32'd0);
      chk("stall busy", 32'(bsy[1]), 32'd1);
      frc[1] = 1'b0;
      wait_done(1, "stall");
      repeat (5) tick();
      check_frame(1, base, 2, 32'h3232_0000, "stall");

      base = ncap[0];
      send(0, 5'd12);
      repeat (4) tick();
      send(0, 5'd5);
      chk("overrun set", 32'(ovr[0]), 32'd1);
      wait_done(0, "overrun");
      repeat (30) tick();
      check_frame(0, base, 4, 32'h3132_0D0A, "overrun");
      chk("overrun sticky", 32'(ovr[0]), 32'd1);

      chk("bare overrun clear", 32'(ovr[1]), 32'd0);
      base = ncap[1];
      send(1, 5'd20);
      wait_done(1, "done-cycle");
      send(1, 5'd7);
      chk("done-cycle overrun", 32'(ovr[1]), 32'd1);
      repeat (20) tick();
      check_frame(1, base, 2, 32'h3230_0000, "done-cycle");

      send(1, 5'd29);
      wait_done(1, "idle-accept first");
      tick();
      base = ncap[1];
      send(1, 5'd4);
      wait_done(1, "idle-accept");
      repeat (5) tick();
      check_frame(1, base, 2, 32'h3034_0000, "idle-accept");

      hold[0] = 20;
      base = ncap[0];
      send(0, 5'd23);
      c = 0;
      while (ncap[0] - base < 2 && c < 500) begin
         tick();
         c++;
      end
      chk("reset test second strobe", 32'(ncap[0] - base), 32'd2);
      repeat (3) tick();
      chk("overrun held before reset", 32'(ovr[0]), 32'd1);
      d0 = ncap[1];
      si[1] = 5'd25;
      sv[1] = 1'b1;
      rst = 1'b1;
      tick();
      check_zero(0, "midframe reset");
      chk("midframe reset bare overrun", 32'(ovr[1]), 32'd0);
      rst = 1'b0;
      sv[1] = 1'b0;
      repeat (150) tick();
      chk("no strobe after reset", 32'(ncap[0] - base), 32'd2);
      chk("no resume busy", 32'(bsy[0]), 32'd0);
      chk("valid in reset ignored strobes", 32'(ncap[1] - d0), 32'd0);
      chk("valid in reset ignored busy", 32'(bsy[1]), 32'd0);
      base = ncap[0];
      send(0, 5'd9);
      wait_done(0, "post-reset");
      repeat (25) tick();
      check_frame(0, base, 4, 32'h3039_0D0A, "post-reset");

      chk("no en while uart busy crlf", 32'(ewb[0]), 32'd0);
      chk("no en while uart busy bare", 32'(ewb[1]), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
